instr_assembler: RTL

INSTR_ASSEMBLER -- requirements
Module: instr_assembler

---
 rtl/rv_pkg.sv | 30 +++
 rtl/instr_encode.sv | 57 +++++
 rtl/instr_assembler.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared constants and types for the instruction assembler:
//               instruction format codes, the canonical NOP word and the
//               run-control state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

  // Instruction format selector values (3-bit fmt port). 6 and 7 are illegal.
  localparam logic [2:0] c_fmt_r = 3'd0;
  localparam logic [2:0] c_fmt_i = 3'd1;
  localparam logic [2:0] c_fmt_s = 3'd2;
  localparam logic [2:0] c_fmt_b = 3'd3;
  localparam logic [2:0] c_fmt_u = 3'd4;
  localparam logic [2:0] c_fmt_j = 3'd5;

  // addi x0, x0, 0 - substituted for any word with an illegal format.
  localparam logic [31:0] c_nop = 32'h0000_0013;

  // Run-control states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_encode.sv
`default_nettype none
// ============================================================================
// Module      : instr_encode
// Description : Purely combinational RV32 field packer. Takes a format code
//               and the raw instruction fields and produces the 32-bit word,
//               plus flags for an illegal format and a misaligned B/J offset.
// Ports       : i_fmt            format selector (rv_pkg c_fmt_*)
//               i_opcode..i_imm  raw instruction fields
//               o_word           packed instruction (NOP when illegal)
//               o_illegal        format code 6 or 7
//               o_misalign       B/J immediate with bit 0 set (bit dropped)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encode
  import rv_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [2:0]  i_funct3,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_illegal,
  output logic        o_misalign
);

  always_comb begin
    o_word     = c_nop;
    o_illegal  = 1'b0;
    o_misalign = 1'b0;
    case (i_fmt)
      c_fmt_r: o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      c_fmt_i: o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
      c_fmt_s: o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
      c_fmt_b: begin
        // Branch offsets are halfword multiples; bit 0 has no slot in the word.
        o_word     = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                      i_imm[4:1], i_imm[11], i_opcode};
        o_misalign = i_imm[0];
      end
      c_fmt_u: o_word = {i_imm[31:12], i_rd, i_opcode};
      c_fmt_j: begin
        o_word     = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
        o_misalign = i_imm[0];
      end
      default: begin
        o_word    = c_nop;
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_assembler.sv
`default_nettype none
// ============================================================================
// Module      : instr_assembler
// Description : Accepts a stream of instruction field bundles, packs each one
//               into a 32-bit RV32 word and writes the words to consecutive
//               instruction-memory addresses starting at base_addr.
// Ports       : clk, rst_n                 clock / async active-low reset
//               start, base_addr, num_words run request (sampled in IDLE only)
//               in_valid, in_ready          field-bundle handshake
//               fmt, opcode..imm            instruction fields
//               wr_en, wr_addr, wr_data     imem write request (registered)
//               wr_ready                    imem write accept
//               busy, done, err             status (done is a 1-cycle pulse,
//                                           err is sticky until next start)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_assembler
  import rv_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] c_cnt_one  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] c_cnt_zero = '0;

  state_t              state_q,   state_d;
  logic [ADDR_W-1:0]   base_q,    base_d;
  logic [ADDR_W:0]     num_q,     num_d;
  logic [ADDR_W:0]     acc_cnt_q, acc_cnt_d;   // bundles accepted this run
  logic [ADDR_W:0]     wr_cnt_q,  wr_cnt_d;    // words written this run
  logic                wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic                busy_q,    busy_d;
  logic                done_q,    done_d;
  logic                err_q,     err_d;

  logic [31:0]         w_word;
  logic                w_illegal;
  logic                w_misalign;
  logic                w_in_ready;
  logic                w_accept;
  logic                w_wr_fire;

  instr_encode u_encode (
    .i_fmt      (fmt),
    .i_opcode   (opcode),
    .i_rd       (rd),
    .i_funct3   (funct3),
    .i_rs1      (rs1),
    .i_rs2      (rs2),
    .i_funct7   (funct7),
    .i_imm      (imm),
    .o_word     (w_word),
    .o_illegal  (w_illegal),
    .o_misalign (w_misalign)
  );

  // The output register can take a new word when it is empty or is being
  // drained this very cycle, which gives one word/cycle with wr_ready high.
  // Derived only from flops and wr_ready, so it drops to 0 as soon as the
  // state flop is reset.
  assign w_in_ready = (state_q == S_RUN) && (acc_cnt_q < num_q) &&
                      (!wr_en_q || wr_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_wr_fire  = wr_en_q && wr_ready;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    num_d     = num_q;
    acc_cnt_d = acc_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d    = base_addr;
          num_d     = num_words;
          acc_cnt_d = c_cnt_zero;
          wr_cnt_d  = c_cnt_zero;
          err_d     = 1'b0;
          state_d   = (num_words == c_cnt_zero) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_wr_fire) begin
          wr_en_d  = 1'b0;
          wr_cnt_d = wr_cnt_q + c_cnt_one;
          if ((wr_cnt_q + c_cnt_one) == num_q) begin
            state_d = S_DONE;
          end
        end
        // Acceptance overrides the drain above: the register refills in place.
        if (w_accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + acc_cnt_q[ADDR_W-1:0];  // wraps modulo 2^ADDR_W
          wr_data_d = w_word;
          acc_cnt_d = acc_cnt_q + c_cnt_one;
          if (w_illegal || w_misalign) begin
            err_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered from the next state so they line up with it.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      num_q     <= '0;
      acc_cnt_q <= '0;
      wr_cnt_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      num_q     <= num_d;
      acc_cnt_q <= acc_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign in_ready = w_in_ready;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
`default_nettype wire
